edge_output_stage: RTL and testbench
====================================

EDGE_OUTPUT_STAGE -- requirements
Module: edge_output_stage

Interface
REQ-001 Parameter IMG_WIDTH, default 640, active pixels per line.
REQ-002 Parameter IMG_HEIGHT, default 480, active lines per frame.
REQ-003 Parameter BORDER, default 2, leading columns/rows with an invalid 3x3 window.
REQ-004 iCLK  input  1  single clock; all state updates on rising edge.
REQ-005 iRST  input  1  reset, synchronous, active-low.
REQ-006 iSOF  input  1  start-of-frame pulse, one cycle.
REQ-007 iDVAL  input  1  qualifies iPIXEL.
REQ-008 iPIXEL  input  12  unsigned edge magnitude from the convolution stage.
REQ-009 iTHRESH  input  12  binarisation threshold, sampled on each valid pixel.
REQ-010 oRED, oGREEN, oBLUE  output  12 each  display pixel, all three equal.
REQ-011 oDVAL  output  1  qualifies oRED/oGREEN/oBLUE.
REQ-012 oX  output  $clog2(IMG_WIDTH)  column of the current output pixel.
REQ-013 oY  output  $clog2(IMG_HEIGHT)  row of the current output pixel.
REQ-014 oFRAME_DONE  output  1  one-cycle pulse, same cycle as the last pixel of a frame on the outputs.

Function
REQ-015 The FSM SHALL have two states: WAIT_SOF and ACTIVE; the reset state is WAIT_SOF.
REQ-016 In WAIT_SOF: iDVAL ignored, oDVAL=0; iSOF -> ACTIVE with x=0, y=0.
REQ-017 iSOF together with iDVAL (either state): that pixel is accepted as x=0, y=0, and the state is ACTIVE.
REQ-018 iSOF in ACTIVE mid-frame: counters to 0 immediately, no oFRAME_DONE, the frame restarts.
REQ-019 In ACTIVE, each iDVAL=1 cycle: pixel accepted, x increments; x=IMG_WIDTH-1 wraps to 0 and y increments.
REQ-020 Pixel at x=IMG_WIDTH-1, y=IMG_HEIGHT-1: accepted, counters to 0, state -> WAIT_SOF, oFRAME_DONE asserted with that pixel's output.
REQ-021 iDVAL=0 cycles: counters hold; gaps of any length are legal.
REQ-022 Border blanking: accepted pixels with x<BORDER or y<BORDER SHALL output 0.
REQ-023 Latency: exactly 1 cycle; oDVAL, colour, oX, oY and oFRAME_DONE are registered together from the accepting cycle.
REQ-024 oDVAL SHALL be high for exactly one cycle per accepted pixel.
REQ-025 Colour outputs, oX and oY SHALL hold their last value while oDVAL=0.

Reset
REQ-026 While iRST=0 at a clock edge: state=WAIT_SOF, x=y=0, oDVAL=0, oFRAME_DONE=0, oRED=oGREEN=oBLUE=0, oX=oY=0.
REQ-027 Reset mid-frame SHALL discard the frame; the next output requires a new iSOF.

Configuration
REQ-028 Macro EDGE_THRESH_EN defined: a non-border output is 12'hFFF if iPIXEL>=iTHRESH, else 0.
REQ-029 Macro EDGE_THRESH_EN undefined: a non-border output is iPIXEL unchanged, and iTHRESH is ignored.

Structure
REQ-030 The package sobel_pkg SHALL hold PIX_W=12, the default IMG_WIDTH/IMG_HEIGHT/BORDER constants and the FSM state enum.
REQ-031 A single sub-module, frame_pos_counter, SHALL hold the x/y counters with wrap and last-pixel detection; everything else is in edge_output_stage.

Verification (IMG_WIDTH=4, IMG_HEIGHT=3, BORDER=2)
REQ-032 Reset, then 12 pixels of 12'h123 sent with no iSOF -> oDVAL stays 0 throughout.
REQ-033 iSOF, then 12 consecutive pixels 12'h100..12'h10B, macro undefined -> outputs 0 except (x2,y2)=12'h10A and (x3,y2)=12'h10B; oFRAME_DONE high with (x3,y2) only; state -> WAIT_SOF.
REQ-034 Macro defined, iTHRESH=12'h200, interior pixels 12'h1FF then 12'h200 -> outputs 0 then 12'hFFF.
REQ-035 Same frame with random iDVAL gaps of 0-3 cycles -> the same 12 outputs in the same order, each 1 cycle after its accept.
REQ-036 iSOF asserted at pixel 6, then 12 more pixels -> counters restart at (0,0), no oFRAME_DONE from the aborted frame, exactly one oFRAME_DONE at the end.
REQ-037 iRST low for 1 cycle at pixel 5 -> all outputs 0 the next cycle; pixels ignored until the next iSOF.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and types for the edge-detector output stage.
// Holds the pixel width, the default frame geometry and the stage FSM state type.
// No logic; imported by edge_output_stage and frame_pos_counter.
package sobel_pkg;

   localparam int PIX_W          = 12;
   localparam int DEF_IMG_WIDTH  = 640;
   localparam int DEF_IMG_HEIGHT = 480;
   localparam int DEF_BORDER     = 2;

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } state_e;

endpackage

// File: rtl/frame_pos_counter.sv
// Column/row position tracker for the pixel being accepted this cycle, with line wrap and last-pixel flag.
// Latency: position and last flag are combinational from the counters; counters update on the accepting edge.
// Backpressure: none; the counters advance only on acc_i and hold otherwise.
// Ports: clk_i/rst_ni (sync active-low), sof_i restarts at (0,0), acc_i accepts one pixel,
//        pix_x_o/pix_y_o position of the pixel on this cycle, last_o marks the final pixel of a frame.
import sobel_pkg::*;

module frame_pos_counter #(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
)(
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          sof_i,
   input  logic                          acc_i,
   output logic [$clog2(IMG_WIDTH)-1:0]  pix_x_o,
   output logic [$clog2(IMG_HEIGHT)-1:0] pix_y_o,
   output logic                          last_o
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] X_MAX = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(IMG_HEIGHT - 1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   always_comb begin
      // A start-of-frame forces the current pixel to (0,0), so a pixel arriving
      // together with iSOF is the first pixel of the new frame.
      pix_x_o = sof_i ? '0 : x_q;
      pix_y_o = sof_i ? '0 : y_q;
      last_o  = (pix_x_o == X_MAX) && (pix_y_o == Y_MAX);
      x_d     = x_q;
      y_d     = y_q;
      if (acc_i) begin
         if (last_o) begin
            x_d = '0;
            y_d = '0;
         end else if (pix_x_o == X_MAX) begin
            x_d = '0;
            y_d = pix_y_o + YW'(1);
         end else begin
            x_d = pix_x_o + XW'(1);
            y_d = pix_y_o;
         end
      end else if (sof_i) begin
         x_d = '0;
         y_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/edge_output_stage.sv
// Output stage: frames the edge-magnitude stream, blanks the border and drives a grey display pixel.
// Latency: exactly one cycle from the accepting cycle to oDVAL/colour/oX/oY/oFRAME_DONE.
// Backpressure: none; every iDVAL cycle in a frame is accepted, gaps of any length are legal.
// Ports: iCLK, iRST (sync active-low), iSOF, iDVAL, iPIXEL, iTHRESH in; oRED/oGREEN/oBLUE, oDVAL, oX, oY, oFRAME_DONE out.
// Build option: define EDGE_THRESH_EN to binarise interior pixels against iTHRESH (12'hFFF / 0);
//               without it interior pixels pass through and iTHRESH is ignored.
import sobel_pkg::*;

module edge_output_stage #(
   parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
   parameter int BORDER     = DEF_BORDER
)(
   input  logic                          iCLK,
   input  logic                          iRST,
   input  logic                          iSOF,
   input  logic                          iDVAL,
   input  logic [PIX_W-1:0]              iPIXEL,
   input  logic [PIX_W-1:0]              iTHRESH,
   output logic [PIX_W-1:0]              oRED,
   output logic [PIX_W-1:0]              oGREEN,
   output logic [PIX_W-1:0]              oBLUE,
   output logic                          oDVAL,
   output logic [$clog2(IMG_WIDTH)-1:0]  oX,
   output logic [$clog2(IMG_HEIGHT)-1:0] oY,
   output logic                          oFRAME_DONE
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);

   state_e           state_q, state_d;
   logic             accept;
   logic             last_pix;
   logic [XW-1:0]    pix_x;
   logic [YW-1:0]    pix_y;
   logic [PIX_W-1:0] pix_d, pix_q;
   logic [XW-1:0]    x_q;
   logic [YW-1:0]    y_q;
   logic             dval_q, done_q;

   frame_pos_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT)
   ) u_pos (
      .clk_i   (iCLK),
      .rst_ni  (iRST),
      .sof_i   (iSOF),
      .acc_i   (accept),
      .pix_x_o (pix_x),
      .pix_y_o (pix_y),
      .last_o  (last_pix)
   );

   always_comb begin
      // iSOF opens the frame in the same cycle, so a pixel alongside it is taken.
      accept  = iDVAL && ((state_q == ACTIVE) || iSOF);
      state_d = state_q;
      if (accept && last_pix) begin
         state_d = WAIT_SOF;
      end else if (iSOF) begin
         state_d = ACTIVE;
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         state_q <= WAIT_SOF;
      end else begin
         state_q <= state_d;
      end
   end

`ifdef EDGE_THRESH_EN
   always_comb begin
      pix_d = '0;
      if ((int'(pix_x) >= BORDER) && (int'(pix_y) >= BORDER)) begin
         pix_d = (iPIXEL >= iTHRESH) ? '1 : '0;
      end
   end
`else
   logic unused_thresh;
   assign unused_thresh = ^iTHRESH;

   always_comb begin
      pix_d = '0;
      if ((int'(pix_x) >= BORDER) && (int'(pix_y) >= BORDER)) begin
         pix_d = iPIXEL;
      end
   end
`endif

   // Colour and position only load on an accepted pixel so they hold across gaps.
   always_ff @(posedge iCLK) begin
      if (!iRST) begin
         dval_q <= 1'b0;
         done_q <= 1'b0;
         pix_q  <= '0;
         x_q    <= '0;
         y_q    <= '0;
      end else begin
         dval_q <= accept;
         done_q <= accept && last_pix;
         if (accept) begin
            pix_q <= pix_d;
            x_q   <= pix_x;
            y_q   <= pix_y;
         end
      end
   end

   assign oRED        = pix_q;
   assign oGREEN      = pix_q;
   assign oBLUE       = pix_q;
   assign oDVAL       = dval_q;
   assign oX          = x_q;
   assign oY          = y_q;
   assign oFRAME_DONE = done_q;

endmodule

// File: tb/tb_edge_output_stage.sv
module tb_edge_output_stage;

   localparam int W = 4;
   localparam int H = 3;
   localparam int B = 2;

   logic        iCLK, iRST, iSOF, iDVAL;
   logic [11:0] iPIXEL, iTHRESH;
   logic [11:0] oRED, oGREEN, oBLUE;
   logic        oDVAL, oFRAME_DONE;
   logic [1:0]  oX, oY;

   edge_output_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(B)) dut (
      .iCLK(iCLK), .iRST(iRST), .iSOF(iSOF), .iDVAL(iDVAL),
      .iPIXEL(iPIXEL), .iTHRESH(iTHRESH),
      .oRED(oRED), .oGREEN(oGREEN), .oBLUE(oBLUE), .oDVAL(oDVAL),
      .oX(oX), .oY(oY), .oFRAME_DONE(oFRAME_DONE)
   );

   typedef struct {
      logic [11:0] pix;
      logic [1:0]  x;
      logic [1:0]  y;
      logic        done;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   dval_seen = 0;
   int   done_seen = 0;
   logic rst_seen = 1'b0;
   logic mon_en = 1'b0;
   logic [11:0] th = 12'h200;
   logic [11:0] h_pix = '0;
   logic [1:0]  h_x = '0, h_y = '0;

   // reference model state
   logic m_active = 1'b0;
   int   m_x = 0, m_y = 0;

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   always @(posedge iCLK) begin
      cyc++;
      rst_seen = iRST;
   end

   function automatic logic [11:0] model_pix(input logic [11:0] px, input logic [11:0] t,
                                             input int x, input int y);
      if (x < B || y < B) return 12'h000;
`ifdef EDGE_THRESH_EN
      return (px >= t) ? 12'hFFF : 12'h000;
`else
      return px;
`endif
   endfunction

   task automatic drive(input logic rst, input logic sof, input logic dval, input logic [11:0] px);
      logic acc;
      exp_t e;
      iRST = rst; iSOF = sof; iDVAL = dval; iPIXEL = px; iTHRESH = th;
      acc = 1'b0;
      e = '{pix: 12'h0, x: 2'd0, y: 2'd0, done: 1'b0, due: 0};
      if (!rst) begin
         m_active = 1'b0; m_x = 0; m_y = 0;
      end else begin
         if (sof) begin
            m_active = 1'b1; m_x = 0; m_y = 0;
         end
         acc = dval && m_active;
         if (acc) begin
            e.pix  = model_pix(px, th, m_x, m_y);
            e.x    = 2'(m_x);
            e.y    = 2'(m_y);
            e.done = (m_x == W-1) && (m_y == H-1);
            if (e.done) begin
               m_x = 0; m_y = 0; m_active = 1'b0;
            end else if (m_x == W-1) begin
               m_x = 0; m_y = m_y + 1;
            end else begin
               m_x = m_x + 1;
            end
         end
      end
      @(posedge iCLK);
      #1;
      if (acc) begin
         e.due = cyc;
         exp_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 12'h000);
   endtask

   // Scoreboard: every output beat is checked against the head of the queue,
   // including the cycle it was due; idle cycles must hold the last values.
   always @(negedge iCLK) begin
      exp_t e;
      if (mon_en) begin
         if (!rst_seen) begin
            tests++;
            if ({oDVAL, oFRAME_DONE, oRED, oGREEN, oBLUE, oX, oY} !== '0) begin
               fails++;
               $display("FAIL reset_outputs: got dval=%b done=%b pix=%h x=%0d y=%0d, want all zero",
                        oDVAL, oFRAME_DONE, oRED, oX, oY);
            end
         end else if (oDVAL === 1'b1) begin
            dval_seen++;
            if (oFRAME_DONE === 1'b1) done_seen++;
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_output: got pix=%h x=%0d y=%0d at cycle %0d, want no output",
                        oRED, oX, oY, cyc);
            end else begin
               e = exp_q.pop_front();
               if (oRED !== e.pix || oGREEN !== e.pix || oBLUE !== e.pix || oX !== e.x ||
                   oY !== e.y || oFRAME_DONE !== e.done || cyc != e.due) begin
                  fails++;
                  $display("FAIL output_beat: got rgb=%h/%h/%h x=%0d y=%0d done=%b cyc=%0d, want pix=%h x=%0d y=%0d done=%b cyc=%0d",
                           oRED, oGREEN, oBLUE, oX, oY, oFRAME_DONE, cyc, e.pix, e.x, e.y, e.done, e.due);
               end
            end
         end else begin
            tests++;
            if (oFRAME_DONE !== 1'b0 || oRED !== h_pix || oGREEN !== h_pix || oBLUE !== h_pix ||
                oX !== h_x || oY !== h_y) begin
               fails++;
               $display("FAIL idle_hold: got done=%b rgb=%h/%h/%h x=%0d y=%0d, want done=0 pix=%h x=%0d y=%0d",
                        oFRAME_DONE, oRED, oGREEN, oBLUE, oX, oY, h_pix, h_x, h_y);
            end
            if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
               e = exp_q.pop_front();
               tests++;
               fails++;
               $display("FAIL missed_output: got dval=0 at cycle %0d, want pix=%h x=%0d y=%0d",
                        cyc, e.pix, e.x, e.y);
            end
         end
         h_pix = oRED; h_x = oX; h_y = oY;
      end
   end

   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 12'h000);
      drive(1'b0, 1'b1, 1'b1, 12'hABC);
      tests++;
      if (oDVAL !== 1'b0 || oFRAME_DONE !== 1'b0) begin
         fails++;
         $display("FAIL reset_flags: got dval=%b done=%b, want 0/0", oDVAL, oFRAME_DONE);
      end
      tests++;
      if (oRED !== 12'h0 || oGREEN !== 12'h0 || oBLUE !== 12'h0) begin
         fails++;
         $display("FAIL reset_colour: got %h/%h/%h, want 000", oRED, oGREEN, oBLUE);
      end
      tests++;
      if (oX !== 2'd0 || oY !== 2'd0) begin
         fails++;
         $display("FAIL reset_pos: got x=%0d y=%0d, want 0/0", oX, oY);
      end
      mon_en = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) idle(1);
      idle(1);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL %s_drain: got %0d outputs outstanding, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_counts(input string name, input int d0, input int f0, input int nd, input int nf);
      tests++;
      if (dval_seen - d0 != nd || done_seen - f0 != nf) begin
         fails++;
         $display("FAIL %s_counts: got %0d pixels %0d frame_done, want %0d pixels %0d frame_done",
                  name, dval_seen - d0, done_seen - f0, nd, nf);
      end
   endtask

   task automatic test_no_sof();
      int d0 = dval_seen, f0 = done_seen;
      for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b1, 12'h123);
      drain("no_sof");
      check_counts("no_sof", d0, f0, 0, 0);
   endtask

   task automatic test_frame();
      int d0 = dval_seen, f0 = done_seen;
      drive(1'b1, 1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b1, 12'h100 + 12'(i));
      drain("frame");
      check_counts("frame", d0, f0, 12, 1);
      // Back in WAIT_SOF: further pixels must be ignored.
      d0 = dval_seen;
      for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, 12'h7FF);
      drain("after_frame");
      check_counts("after_frame", d0, f0 + 1, 0, 0);
   endtask

   task automatic test_thresh();
      int d0 = dval_seen, f0 = done_seen;
      th = 12'h200;
      for (int i = 0; i < 12; i++)
         drive(1'b1, (i == 0), 1'b1, (i == 10) ? 12'h1FF : (i == 11) ? 12'h200 : 12'h300);
      drain("thresh");
      check_counts("thresh", d0, f0, 12, 1);
   endtask

   task automatic test_gaps();
      int d0 = dval_seen, f0 = done_seen;
      drive(1'b1, 1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, 1'b0, 1'b1, 12'h100 + 12'(i));
         idle(int'($urandom_range(0, 3)));
      end
      drain("gaps");
      check_counts("gaps", d0, f0, 12, 1);
   endtask

   task automatic test_sof_restart();
      int d0 = dval_seen, f0 = done_seen;
      drive(1'b1, 1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, 12'h400 + 12'(i));
      for (int i = 0; i < 12; i++) drive(1'b1, (i == 0), 1'b1, 12'h500 + 12'(i));
      drain("sof_restart");
      check_counts("sof_restart", d0, f0, 18, 1);
   endtask

   task automatic test_reset_mid();
      int d0 = dval_seen, f0 = done_seen;
      drive(1'b1, 1'b1, 1'b0, 12'h000);
      for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b1, 12'h600 + 12'(i));
      drive(1'b0, 1'b0, 1'b1, 12'h605);
      tests++;
      if (oDVAL !== 1'b0 || oRED !== 12'h0 || oX !== 2'd0 || oY !== 2'd0 || oFRAME_DONE !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid: got dval=%b pix=%h x=%0d y=%0d done=%b, want all zero",
                  oDVAL, oRED, oX, oY, oFRAME_DONE);
      end
      for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, 12'h606 + 12'(i));
      drain("reset_mid");
      check_counts("reset_mid", d0, f0, 5, 0);
      d0 = dval_seen;
      for (int i = 0; i < 12; i++) drive(1'b1, (i == 0), 1'b1, 12'h700 + 12'(i));
      drain("reset_recover");
      check_counts("reset_recover", d0, f0, 12, 1);
   endtask

   task automatic test_back_to_back();
      int d0 = dval_seen, f0 = done_seen;
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 12; i++)
            drive(1'b1, (i == 0), 1'b1, 12'h800 + 12'(f * 16 + i));
      drain("back_to_back");
      check_counts("back_to_back", d0, f0, 24, 2);
   endtask

   initial begin
      iRST = 1'b0; iSOF = 1'b0; iDVAL = 1'b0; iPIXEL = '0; iTHRESH = '0;
      test_reset();
      test_no_sof();
      test_frame();
      test_thresh();
      test_gaps();
      test_sof_restart();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
